// File: rtl/spi_rom_arb_pkg.sv
// rtl/spi_rom_arb_pkg.sv - shared types and parked-pad constants for the SPI flash arbiter
package spi_rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } arb_state_t;

  typedef logic master_idx_t;

  localparam logic       PARK_CS_N = 1'b1;
  localparam logic [3:0] PARK_OEN  = 4'hF;

endpackage

// File: rtl/spi_rom_startup.sv
// rtl/spi_rom_startup.sv - post-reset dummy CCLK toggles and CPU reset release
module spi_rom_startup
  import spi_rom_arb_pkg::*;
#(
  parameter int DUMMY_CYCLES = 15
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_cclk,
  output logic o_cpu_rstn,
  output logic o_done
);

  localparam int            CW   = $clog2(DUMMY_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(DUMMY_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_cclk;
  logic          r_cpu_rstn;

  // One toggle per edge until the count is spent, then a single edge releases the CPU.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt      <= '0;
      r_cclk     <= 1'b0;
      r_cpu_rstn <= 1'b0;
    end else if (r_cnt != LAST) begin
      r_cnt  <= r_cnt + CW'(1);
      r_cclk <= ~r_cclk;
    end else if (!r_cpu_rstn) begin
      r_cpu_rstn <= 1'b1;
      r_cclk     <= 1'b0;
    end
  end

  assign o_cclk     = r_cclk;
  assign o_cpu_rstn = r_cpu_rstn;
  assign o_done     = (r_cnt == LAST) && !r_cpu_rstn;

endmodule

// File: rtl/spi_rom_arb.sv
// rtl/spi_rom_arb.sv - startup sequencer and two-master round-robin arbiter for the config SPI flash
// Optional grant timeout enabled by defining SPI_ROM_ARB_TIMEOUT_EN.
module spi_rom_arb
  import spi_rom_arb_pkg::*;
#(
  parameter int DUMMY_CYCLES   = 15,
  parameter int IDLE_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic [1:0]      m_req,
  output logic [1:0]      m_gnt,
  input  logic [1:0]      m_cs_n,
  input  logic [1:0]      m_sclk,
  input  logic [1:0][3:0] m_o,
  input  logic [1:0][3:0] m_oen,
  output logic [3:0]      m_i,
  output logic            pad_cs_n,
  output logic            usrcclko,
  output logic [3:0]      pad_o,
  output logic [3:0]      pad_oen,
  input  logic [3:0]      pad_i,
  output logic            cpu_rstn,
  output logic            err
);

  arb_state_t  r_state, w_state_nxt;
  master_idx_t r_owner, w_owner_nxt;
  master_idx_t r_last,  w_last_nxt;
  logic [15:0] r_gap_cnt, w_gap_nxt;
  logic        r_err, w_err_nxt;
  logic [1:0]  r_block, w_block_nxt;

  logic        w_dummy_cclk;
  logic        w_cpu_rstn;
  logic        w_done;
  logic        w_timeout;
  logic [1:0]  w_req_eff;
  master_idx_t w_pick;

  spi_rom_startup #(
    .DUMMY_CYCLES(DUMMY_CYCLES)
  ) u_startup (
    .i_clk      (sys_clk),
    .i_rstn     (rst),
    .o_cclk     (w_dummy_cclk),
    .o_cpu_rstn (w_cpu_rstn),
    .o_done     (w_done)
  );

`ifdef SPI_ROM_ARB_TIMEOUT_EN
  logic [31:0] r_tcnt;

  always_ff @(posedge sys_clk) begin
    if (!rst || r_state != ST_GRANT) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign w_timeout = (r_state == ST_GRANT) && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  // A revoked master stays masked until it lets go of its request.
  assign w_req_eff = m_req & ~r_block;
  assign w_pick    = (&w_req_eff) ? ~r_last : w_req_eff[1];

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state   <= ST_STARTUP;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_gap_cnt <= '0;
      r_err     <= 1'b0;
      r_block   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_err     <= w_err_nxt;
      r_block   <= w_block_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_gap_nxt   = r_gap_cnt;
    w_err_nxt   = r_err;
    w_block_nxt = r_block & m_req;
    case (r_state)
      ST_STARTUP: begin
        if (w_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (|w_req_eff) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
        end
      end
      ST_GRANT: begin
        if (!m_req[r_owner]) begin
          if (!m_cs_n[r_owner]) w_err_nxt = 1'b1;
          w_state_nxt = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
          w_gap_nxt   = '0;
        end else if (w_timeout) begin
          w_err_nxt            = 1'b1;
          w_block_nxt[r_owner] = 1'b1;
          w_state_nxt          = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
          w_gap_nxt            = '0;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 16'(IDLE_GAP - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 16'd1;
        end
      end
      default: w_state_nxt = ST_STARTUP;
    endcase
  end

  // Pads are parked everywhere except the dummy clock in STARTUP and the owner's pins in GRANT.
  always_comb begin
    m_gnt    = '0;
    pad_cs_n = PARK_CS_N;
    usrcclko = 1'b0;
    pad_o    = '0;
    pad_oen  = PARK_OEN;
    case (r_state)
      ST_STARTUP: usrcclko = w_dummy_cclk;
      ST_GRANT: begin
        m_gnt[r_owner] = 1'b1;
        pad_cs_n       = m_cs_n[r_owner];
        usrcclko       = m_sclk[r_owner];
        pad_o          = m_o[r_owner];
        pad_oen        = m_oen[r_owner];
      end
      default: ;
    endcase
  end

  assign m_i      = pad_i;
  assign cpu_rstn = w_cpu_rstn;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_rom_arb.sv
// tb/tb_spi_rom_arb.sv - directed self-checking bench with a grant-order scoreboard
module tb_spi_rom_arb;

  logic            sys_clk;
  logic            rst;
  logic [1:0]      m_req;
  logic [1:0]      m_gnt;
  logic [1:0]      m_cs_n;
  logic [1:0]      m_sclk;
  logic [1:0][3:0] m_o;
  logic [1:0][3:0] m_oen;
  logic [3:0]      m_i;
  logic            pad_cs_n;
  logic            usrcclko;
  logic [3:0]      pad_o;
  logic [3:0]      pad_oen;
  logic [3:0]      pad_i;
  logic            cpu_rstn;
  logic            err;

`ifdef SPI_ROM_ARB_TIMEOUT_EN
  localparam int   EXP_TMO_GNT = 8;
  localparam logic EXP_TMO_ERR = 1'b1;
`else
  localparam int   EXP_TMO_GNT = 20;
  localparam logic EXP_TMO_ERR = 1'b0;
`endif

  typedef struct {
    logic [1:0] gnt;
    int         idle;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic       mon_en   = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  int         idle_cnt = 0;
  int         n_pass   = 0;
  int         n_total  = 0;

  spi_rom_arb #(
    .DUMMY_CYCLES   (15),
    .IDLE_GAP       (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_gnt    (m_gnt),
    .m_cs_n   (m_cs_n),
    .m_sclk   (m_sclk),
    .m_o      (m_o),
    .m_oen    (m_oen),
    .m_i      (m_i),
    .pad_cs_n (pad_cs_n),
    .usrcclko (usrcclko),
    .pad_o    (pad_o),
    .pad_oen  (pad_oen),
    .pad_i    (pad_i),
    .cpu_rstn (cpu_rstn),
    .err      (err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input logic [1:0] g, input int idle);
    exp_t t;
    t.gnt  = g;
    t.idle = idle;
    sb.push_back(t);
  endtask

  task automatic wait_gnt(input int m);
    int k;
    k = 0;
    while (m_gnt[m] !== 1'b1 && k < 64) begin
      clk_n(1);
      k++;
    end
    chk("wait_gnt", 32'(m_gnt[m]), 32'd1);
  endtask

  // Counts usrcclko toggles while cpu_rstn is low and records edge numbers after rst release.
  task automatic run_startup(output int tog, output int rstn_e, output int gnt_e);
    logic prev;
    prev   = usrcclko;
    tog    = 0;
    rstn_e = 0;
    gnt_e  = 0;
    for (int e = 1; e <= 20; e++) begin
      clk_n(1);
      if (!cpu_rstn && usrcclko !== prev) tog++;
      prev = usrcclko;
      if (cpu_rstn && rstn_e == 0) rstn_e = e;
      if (m_gnt != 2'b00 && gnt_e == 0) gnt_e = e;
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (prev_gnt == 2'b00 && m_gnt != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_gnt", 32'(m_gnt), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("gnt_order", 32'(m_gnt), 32'(mon_e.gnt));
          if (mon_e.idle >= 0) chk("gnt_idle_gap", 32'(idle_cnt), 32'(mon_e.idle));
        end
      end
      if (m_gnt == 2'b00) idle_cnt++;
      else idle_cnt = 0;
      prev_gnt = m_gnt;
    end
  end

  initial begin
    int tog, re, ge, gcnt;
    rst    = 1'b0;
    m_req  = 2'b00;
    m_cs_n = 2'b11;
    m_sclk = 2'b00;
    m_o    = '0;
    m_oen  = '1;
    pad_i  = 4'h0;
    clk_n(2);
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_cs_n", 32'(pad_cs_n), 32'd1);
    chk("rst_cclk", 32'(usrcclko), 32'd0);
    chk("rst_pad_o", 32'(pad_o), 32'd0);
    chk("rst_oen", 32'(pad_oen), 32'hF);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    pad_i = 4'hA;
    #1;
    chk("m_i_pass", 32'(m_i), 32'hA);

    mon_en = 1'b1;
    push(2'b01, -1);
    m_req = 2'b11;
    rst   = 1'b1;
    run_startup(tog, re, ge);
    chk("startup_toggles", 32'(tog), 32'd15);
    chk("startup_rstn_edge", 32'(re), 32'd16);
    chk("startup_gnt_edge", 32'(ge), 32'd17);

    push(2'b10, 3);
    clk_n(7);
    m_req[0] = 1'b0;
    clk_n(1);
    m_req[0] = 1'b1;
    wait_gnt(1);
    push(2'b01, 3);
    clk_n(10);
    m_req[1] = 1'b0;
    clk_n(1);
    m_req[1] = 1'b1;
    wait_gnt(0);
    push(2'b10, 3);
    clk_n(10);
    m_req[0] = 1'b0;
    wait_gnt(1);
    clk_n(10);
    m_req[1] = 1'b0;
    clk_n(5);
    chk("rr_err_clean", 32'(err), 32'd0);

    push(2'b10, -1);
    m_req[1] = 1'b1;
    clk_n(1);
    chk("p1_gnt_latency", 32'(m_gnt), 32'h2);
    m_cs_n    = 2'b01;
    m_sclk    = 2'b10;
    m_o[1]    = 4'h5;
    m_oen[1]  = 4'b1110;
    m_o[0]    = 4'hA;
    m_oen[0]  = 4'h0;
    #1;
    chk("p1_cs_n", 32'(pad_cs_n), 32'd0);
    chk("p1_cclk", 32'(usrcclko), 32'd1);
    chk("p1_pad_o", 32'(pad_o), 32'h5);
    chk("p1_oen", 32'(pad_oen), 32'hE);
    m_sclk[1] = 1'b0;
    #1;
    chk("p1_cclk_follow", 32'(usrcclko), 32'd0);
    m_cs_n[1] = 1'b1;
    m_req[1]  = 1'b0;
    clk_n(1);
    for (int i = 0; i < 3; i++) begin
      chk("park_gnt", 32'(m_gnt), 32'd0);
      chk("park_oen", 32'(pad_oen), 32'hF);
      chk("park_pad_o", 32'(pad_o), 32'd0);
      chk("park_cs_n", 32'(pad_cs_n), 32'd1);
      if (i < 2) clk_n(1);
    end
    chk("p1_err_clean", 32'(err), 32'd0);
    clk_n(2);

    push(2'b10, -1);
    m_req[1] = 1'b1;
    gcnt     = 0;
    for (int i = 0; i < 20; i++) begin
      clk_n(1);
      if (m_gnt[1]) gcnt++;
    end
    chk("tmo_gnt_cycles", 32'(gcnt), 32'(EXP_TMO_GNT));
    chk("tmo_err", 32'(err), 32'(EXP_TMO_ERR));
    m_req[1] = 1'b0;
    clk_n(4);

    push(2'b01, -1);
    m_req[0] = 1'b1;
    wait_gnt(0);
    m_cs_n[0] = 1'b0;
    clk_n(2);
    m_req[0] = 1'b0;
    clk_n(1);
    chk("cs_err_pad_cs_n", 32'(pad_cs_n), 32'd1);
    chk("cs_err_gnt", 32'(m_gnt), 32'd0);
    chk("cs_err_set", 32'(err), 32'd1);
    m_cs_n[0] = 1'b1;
    clk_n(3);
    push(2'b01, -1);
    m_req[0] = 1'b1;
    wait_gnt(0);
    clk_n(3);
    m_req[0] = 1'b0;
    clk_n(1);
    chk("cs_err_sticky", 32'(err), 32'd1);
    clk_n(3);

    push(2'b01, -1);
    m_req[0] = 1'b1;
    wait_gnt(0);
    clk_n(2);
    #1;
    chk("p0_oen_mirror", 32'(pad_oen), 32'h0);
    rst = 1'b0;
    clk_n(1);
    chk("mid_rst_gnt", 32'(m_gnt), 32'd0);
    chk("mid_rst_cs_n", 32'(pad_cs_n), 32'd1);
    chk("mid_rst_oen", 32'(pad_oen), 32'hF);
    chk("mid_rst_cclk", 32'(usrcclko), 32'd0);
    chk("mid_rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    push(2'b01, -1);
    run_startup(tog, re, ge);
    chk("rerun_toggles", 32'(tog), 32'd15);
    chk("rerun_rstn_edge", 32'(re), 32'd16);
    chk("rerun_gnt_edge", 32'(ge), 32'd17);

    m_req = 2'b00;
    clk_n(5);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
